// File: rtl/tl_a_arbiter_pkg.sv
// Shared definitions for the TileLink-UL A-channel arbiter.
//   - A/D opcode encodings used by the arbiter
//   - has_data(): whether an A message carries write data
//   - num_beats(): how many 8-byte beats an A message occupies
package tl_arb_pkg;

    localparam int BEAT_BYTES = 8;
    localparam int BEAT_SHIFT = 3;  // log2(BEAT_BYTES)

    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        GET         = 3'd4
    } a_opcode_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } d_opcode_e;

    // Puts carry data; Get (and anything with opcode[2] set) does not.
    function automatic logic has_data(input logic [2:0] opcode);
        return !opcode[2];
    endfunction

    // Beats of a message: one beat per BEAT_BYTES of payload, at least one,
    // and sizes above 64 bytes are clamped to 8 beats.
    function automatic logic [3:0] num_beats(input logic [2:0] opcode, input logic [2:0] size);
        if (!has_data(opcode) || size <= 3'(BEAT_SHIFT)) return 4'd1;
        if (size >= 3'd6) return 4'd8;
        return 4'd1 << (size - 3'(BEAT_SHIFT));
    endfunction

endpackage

// File: rtl/tl_a_arbiter_rr_arbiter.sv
// N-way round-robin grant.
//   valid     : request vector
//   ptr       : highest-priority index for this cycle
//   grant_oh  : one-hot of grant_idx
//   grant_idx : first valid index scanning ptr, ptr+1, ... modulo N
//               (equals ptr when nothing is valid)
// N must be a power of two so that index arithmetic wraps naturally.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned and no latch is inferred.
        grant_idx = ptr;
        grant_oh  = '0;
        cand      = ptr;
        // Scan from the farthest offset to the nearest so the valid requester
        // closest to ptr is the last (winning) assignment.
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr + IW'(k);
            if (valid[cand]) grant_idx = cand;
        end
        grant_oh[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/tl_a_arbiter.sv
// Shares one TileLink-UL master port between N_IN requesters.
//   clock, reset        : system clock, synchronous active-high reset
//   in_a_*  (per req)   : requester A channels, payload slice i = requester i
//   in_d_*              : D valid per requester, D payload broadcast
//   out_a_*             : merged A channel, source = {requester, source}
//   out_d_*             : downstream D channel, routed by source MSBs
// A is round-robin arbitrated and held on one requester for the whole of a
// multi-beat Put burst. D is purely combinational steering.
module tl_a_arbiter
    import tl_arb_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int IN_SRC_W  = 4,
    parameter int OUT_SRC_W = 5,
    parameter int ADDR_W    = 26,
    parameter int DATA_W    = 64
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic [N_IN-1:0]            in_a_valid,
    output logic [N_IN-1:0]            in_a_ready,
    input  logic [3*N_IN-1:0]          in_a_bits_opcode,
    input  logic [3*N_IN-1:0]          in_a_bits_size,
    input  logic [IN_SRC_W*N_IN-1:0]   in_a_bits_source,
    input  logic [ADDR_W*N_IN-1:0]     in_a_bits_address,
    input  logic [8*N_IN-1:0]          in_a_bits_mask,
    input  logic [DATA_W*N_IN-1:0]     in_a_bits_data,

    output logic [N_IN-1:0]            in_d_valid,
    input  logic [N_IN-1:0]            in_d_ready,
    output logic [2:0]                 in_d_bits_opcode,
    output logic [2:0]                 in_d_bits_size,
    output logic [IN_SRC_W-1:0]        in_d_bits_source,
    output logic [DATA_W-1:0]          in_d_bits_data,

    output logic                       out_a_valid,
    input  logic                       out_a_ready,
    output logic [2:0]                 out_a_bits_opcode,
    output logic [2:0]                 out_a_bits_size,
    output logic [OUT_SRC_W-1:0]       out_a_bits_source,
    output logic [ADDR_W-1:0]          out_a_bits_address,
    output logic [7:0]                 out_a_bits_mask,
    output logic [DATA_W-1:0]          out_a_bits_data,

    input  logic                       out_d_valid,
    output logic                       out_d_ready,
    input  logic [2:0]                 out_d_bits_opcode,
    input  logic [2:0]                 out_d_bits_size,
    input  logic [OUT_SRC_W-1:0]       out_d_bits_source,
    input  logic [DATA_W-1:0]          out_d_bits_data
);

    localparam int IW = $clog2(N_IN);

    logic [IW-1:0]   rr_ptr;
    logic            locked;
    logic [IW-1:0]   owner;
    logic [2:0]      beats_left;

    logic [N_IN-1:0] arb_oh;
    logic [IW-1:0]   arb_idx;
    logic [N_IN-1:0] grant_oh;
    logic [IW-1:0]   grant;
    logic [3:0]      a_beats;
    logic            fire;
    logic [IW-1:0]   d_sel;

    // ---------------- A channel ----------------
    rr_arbiter #(.N(N_IN), .IW(IW)) u_rr (
        .valid     (in_a_valid),
        .ptr       (rr_ptr),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx)
    );

    // A burst in progress pins the grant on its owner even while the owner
    // is idle, so no other requester can interleave beats.
    assign grant    = locked ? owner : arb_idx;
    assign grant_oh = locked ? (N_IN'(1) << owner) : arb_oh;

    assign in_a_ready         = grant_oh & {N_IN{out_a_ready}};
    assign out_a_valid        = in_a_valid[grant];
    assign out_a_bits_opcode  = in_a_bits_opcode[grant*3 +: 3];
    assign out_a_bits_size    = in_a_bits_size[grant*3 +: 3];
    assign out_a_bits_source  = {grant, in_a_bits_source[grant*IN_SRC_W +: IN_SRC_W]};
    assign out_a_bits_address = in_a_bits_address[grant*ADDR_W +: ADDR_W];
    assign out_a_bits_mask    = in_a_bits_mask[grant*BEAT_BYTES +: BEAT_BYTES];
    assign out_a_bits_data    = in_a_bits_data[grant*DATA_W +: DATA_W];

    assign fire    = out_a_valid && out_a_ready;
    assign a_beats = num_beats(out_a_bits_opcode, out_a_bits_size);

    // rr_ptr only advances on the first beat of a message; later beats of a
    // burst are accounted for by beats_left alone.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            rr_ptr     <= '0;
            locked     <= 1'b0;
            owner      <= '0;
            beats_left <= '0;
        end else if (fire) begin
            if (locked) begin
                beats_left <= beats_left - 3'd1;
                if (beats_left == 3'd1) locked <= 1'b0;
            end else begin
                rr_ptr <= grant + IW'(1);
                if (a_beats > 4'd1) begin
                    locked     <= 1'b1;
                    owner      <= grant;
                    beats_left <= 3'(a_beats - 4'd1);
                end
            end
        end
    end

    // ---------------- D channel ----------------
    assign d_sel = out_d_bits_source[OUT_SRC_W-1 -: IW];

    always_comb begin
        in_d_valid        = '0;
        in_d_valid[d_sel] = out_d_valid;
    end

    assign out_d_ready      = in_d_ready[d_sel];
    assign in_d_bits_opcode = out_d_bits_opcode;
    assign in_d_bits_size   = out_d_bits_size;
    assign in_d_bits_source = out_d_bits_source[IN_SRC_W-1:0];
    assign in_d_bits_data   = out_d_bits_data;

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Self-checking bench for tl_a_arbiter: directed scenarios followed by random
// traffic. Expected A beats and D responses are queued by the stimulus side
// from a message-level model; a monitor pops and compares them whenever the
// DUT presents a fired A beat or a D valid.
module tb_tl_a_arbiter;

    localparam int N_IN      = 2;
    localparam int IN_SRC_W  = 4;
    localparam int OUT_SRC_W = 5;
    localparam int ADDR_W    = 26;
    localparam int DATA_W    = 64;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [N_IN-1:0]          in_a_valid;
    logic [N_IN-1:0]          in_a_ready;
    logic [3*N_IN-1:0]        in_a_bits_opcode;
    logic [3*N_IN-1:0]        in_a_bits_size;
    logic [IN_SRC_W*N_IN-1:0] in_a_bits_source;
    logic [ADDR_W*N_IN-1:0]   in_a_bits_address;
    logic [8*N_IN-1:0]        in_a_bits_mask;
    logic [DATA_W*N_IN-1:0]   in_a_bits_data;
    logic [N_IN-1:0]          in_d_valid;
    logic [N_IN-1:0]          in_d_ready;
    logic [2:0]               in_d_bits_opcode;
    logic [2:0]               in_d_bits_size;
    logic [IN_SRC_W-1:0]      in_d_bits_source;
    logic [DATA_W-1:0]        in_d_bits_data;
    logic                     out_a_valid;
    logic                     out_a_ready;
    logic [2:0]               out_a_bits_opcode;
    logic [2:0]               out_a_bits_size;
    logic [OUT_SRC_W-1:0]     out_a_bits_source;
    logic [ADDR_W-1:0]        out_a_bits_address;
    logic [7:0]               out_a_bits_mask;
    logic [DATA_W-1:0]        out_a_bits_data;
    logic                     out_d_valid;
    logic                     out_d_ready;
    logic [2:0]               out_d_bits_opcode;
    logic [2:0]               out_d_bits_size;
    logic [OUT_SRC_W-1:0]     out_d_bits_source;
    logic [DATA_W-1:0]        out_d_bits_data;

    tl_a_arbiter #(
        .N_IN(N_IN), .IN_SRC_W(IN_SRC_W), .OUT_SRC_W(OUT_SRC_W),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clock(clock), .reset(reset),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
        .in_a_bits_opcode(in_a_bits_opcode), .in_a_bits_size(in_a_bits_size),
        .in_a_bits_source(in_a_bits_source), .in_a_bits_address(in_a_bits_address),
        .in_a_bits_mask(in_a_bits_mask), .in_a_bits_data(in_a_bits_data),
        .in_d_valid(in_d_valid), .in_d_ready(in_d_ready),
        .in_d_bits_opcode(in_d_bits_opcode), .in_d_bits_size(in_d_bits_size),
        .in_d_bits_source(in_d_bits_source), .in_d_bits_data(in_d_bits_data),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_size(out_a_bits_size),
        .out_a_bits_source(out_a_bits_source), .out_a_bits_address(out_a_bits_address),
        .out_a_bits_mask(out_a_bits_mask), .out_a_bits_data(out_a_bits_data),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
        .out_d_bits_opcode(out_d_bits_opcode), .out_d_bits_size(out_d_bits_size),
        .out_d_bits_source(out_d_bits_source), .out_d_bits_data(out_d_bits_data)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2:0]           opcode;
        logic [2:0]           size;
        logic [OUT_SRC_W-1:0] source;
        logic [ADDR_W-1:0]    address;
        logic [7:0]           mask;
        logic [DATA_W-1:0]    data;
        logic [N_IN-1:0]      ready;
    } a_exp_t;

    typedef struct {
        logic [N_IN-1:0]      valid;
        logic                 rdy;
        logic [2:0]           opcode;
        logic [2:0]           size;
        logic [IN_SRC_W-1:0]  source;
        logic [DATA_W-1:0]    data;
    } d_exp_t;

    a_exp_t a_q[$];
    d_exp_t d_q[$];
    a_exp_t a_mon;
    d_exp_t d_mon;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- requester stimulus ----------------
    logic              r_valid [N_IN];
    logic [2:0]        r_op    [N_IN];
    logic [2:0]        r_size  [N_IN];
    logic [IN_SRC_W-1:0] r_src [N_IN];
    logic [ADDR_W-1:0] r_addr  [N_IN];
    logic [7:0]        r_mask  [N_IN];
    logic [DATA_W-1:0] r_data  [N_IN];

    // Message-level model: who was granted last, and any burst in progress.
    int last_grant;
    int burst_owner;
    int burst_left;

    function automatic int model_beats(input logic [2:0] op, input logic [2:0] sz);
        int bytes;
        if (op >= 3'd4) return 1;          // Get-class: no data
        bytes = 1 << sz;
        if (bytes <= 8) return 1;
        if (bytes >= 64) return 8;
        return bytes / 8;
    endfunction

    task automatic model_reset();
        last_grant  = N_IN - 1;            // next scan starts at requester 0
        burst_owner = -1;
        burst_left  = 0;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op,
                           input logic [2:0] sz, input logic [IN_SRC_W-1:0] src);
        r_valid[i] = v;
        r_op[i]    = op;
        r_size[i]  = sz;
        r_src[i]   = src;
        r_addr[i]  = ADDR_W'($urandom);
        r_mask[i]  = 8'($urandom);
        r_data[i]  = {$urandom, $urandom};
    endtask

    task automatic clear_all();
        for (int i = 0; i < N_IN; i++) set_req(i, 1'b0, 3'd4, 3'd0, '0);
        out_a_ready       = 1'b0;
        out_d_valid       = 1'b0;
        out_d_bits_opcode = '0;
        out_d_bits_size   = '0;
        out_d_bits_source = '0;
        out_d_bits_data   = '0;
        in_d_ready        = '0;
    endtask

    task automatic pack();
        for (int i = 0; i < N_IN; i++) begin
            in_a_valid[i]                          = r_valid[i];
            in_a_bits_opcode[i*3 +: 3]             = r_op[i];
            in_a_bits_size[i*3 +: 3]               = r_size[i];
            in_a_bits_source[i*IN_SRC_W +: IN_SRC_W] = r_src[i];
            in_a_bits_address[i*ADDR_W +: ADDR_W]  = r_addr[i];
            in_a_bits_mask[i*8 +: 8]               = r_mask[i];
            in_a_bits_data[i*DATA_W +: DATA_W]     = r_data[i];
        end
    endtask

    // Apply the current stimulus for one cycle: drive, predict, then advance.
    // Called at posedge+1; returns at the following posedge+1.
    task automatic step();
        int     g;
        a_exp_t ea;
        d_exp_t ed;
        int     req;
        pack();
        g = -1;
        if (burst_owner >= 0) g = burst_owner;
        else begin
            for (int k = 1; k <= N_IN; k++) begin
                if (g < 0 && r_valid[(last_grant + k) % N_IN]) g = (last_grant + k) % N_IN;
            end
        end
        if (g >= 0 && r_valid[g] && out_a_ready) begin
            ea.opcode  = r_op[g];
            ea.size    = r_size[g];
            ea.source  = OUT_SRC_W'((g << IN_SRC_W) + int'(r_src[g]));
            ea.address = r_addr[g];
            ea.mask    = r_mask[g];
            ea.data    = r_data[g];
            ea.ready   = N_IN'(1 << g);
            a_q.push_back(ea);
            if (burst_owner >= 0) begin
                burst_left--;
                if (burst_left == 0) burst_owner = -1;
            end else begin
                last_grant = g;
                if (model_beats(r_op[g], r_size[g]) > 1) begin
                    burst_owner = g;
                    burst_left  = model_beats(r_op[g], r_size[g]) - 1;
                end
            end
        end
        if (out_d_valid) begin
            req       = int'(out_d_bits_source) >> IN_SRC_W;
            ed.valid  = N_IN'(1 << req);
            ed.rdy    = in_d_ready[req];
            ed.opcode = out_d_bits_opcode;
            ed.size   = out_d_bits_size;
            ed.source = IN_SRC_W'(int'(out_d_bits_source) % (1 << IN_SRC_W));
            ed.data   = out_d_bits_data;
            d_q.push_back(ed);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_all();
        pack();
        reset = 1'b1;
        @(negedge clock);
        check("reset_out_a_valid", {63'd0, out_a_valid}, 64'd0);
        check("reset_in_d_valid", 64'(in_d_valid), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drive_d(input logic v, input logic [OUT_SRC_W-1:0] src, input logic [N_IN-1:0] rdy);
        out_d_valid       = v;
        out_d_bits_source = src;
        out_d_bits_opcode = 3'($urandom_range(0, 1));
        out_d_bits_size   = 3'($urandom_range(0, 7));
        out_d_bits_data   = {$urandom, $urandom};
        in_d_ready        = rdy;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (out_a_valid === 1'b1 && out_a_ready === 1'b1) begin
            if (a_q.size() == 0) begin
                check("a_spurious_fire", {63'd0, out_a_valid}, 64'd0);
            end else begin
                a_mon = a_q.pop_front();
                check("a_source",  64'(out_a_bits_source),  64'(a_mon.source));
                check("a_opcode",  64'(out_a_bits_opcode),  64'(a_mon.opcode));
                check("a_size",    64'(out_a_bits_size),    64'(a_mon.size));
                check("a_address", 64'(out_a_bits_address), 64'(a_mon.address));
                check("a_mask",    64'(out_a_bits_mask),    64'(a_mon.mask));
                check("a_data",    out_a_bits_data,         a_mon.data);
                check("a_in_ready", 64'(in_a_ready),        64'(a_mon.ready));
            end
        end
        if (in_d_valid !== '0) begin
            if (d_q.size() == 0) begin
                check("d_spurious_valid", 64'(in_d_valid), 64'd0);
            end else begin
                d_mon = d_q.pop_front();
                check("d_valid",  64'(in_d_valid),       64'(d_mon.valid));
                check("d_ready",  {63'd0, out_d_ready},  {63'd0, d_mon.rdy});
                check("d_opcode", 64'(in_d_bits_opcode), 64'(d_mon.opcode));
                check("d_size",   64'(in_d_bits_size),   64'(d_mon.size));
                check("d_source", 64'(in_d_bits_source), 64'(d_mon.source));
                check("d_data",   in_d_bits_data,        d_mon.data);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        clear_all();
        pack();
        model_reset();
        @(posedge clock);
        #1;
        do_reset();

        // Single Get from requester 0, then its D response.
        set_req(0, 1'b1, 3'd4, 3'd3, 4'd3);
        out_a_ready = 1'b1;
        step();
        clear_all();
        drive_d(1'b1, 5'b00011, 2'b01);
        step();
        clear_all();

        // Both requesters streaming single-beat Puts: 0,1,0,1,...
        do_reset();
        out_a_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            set_req(0, 1'b1, 3'd0, 3'd3, 4'(c));
            set_req(1, 1'b1, 3'd1, 3'd2, 4'(c + 8));
            step();
        end

        // Requester 0 alone, then requester 1 8-beat burst with 0 waiting.
        clear_all();
        out_a_ready = 1'b1;
        set_req(0, 1'b1, 3'd4, 3'd3, 4'd1);
        step();
        for (int c = 0; c < 9; c++) begin
            set_req(0, 1'b1, 3'd0, 3'd3, 4'd5);
            set_req(1, 1'b1, 3'd0, 3'd6, 4'd9);
            step();
        end

        // Burst under a toggling out_a_ready; requester 0 must wait it out.
        for (int c = 0; c < 18; c++) begin
            set_req(0, 1'b1, 3'd1, 3'd0, 4'd2);
            set_req(1, 1'b1, 3'd0, 3'd6, 4'd12);
            out_a_ready = (c % 2 == 0);
            step();
        end

        // D routing with the target requester not ready, then ready.
        clear_all();
        drive_d(1'b1, 5'b10111, 2'b01);
        step();
        drive_d(1'b1, 5'b10111, 2'b11);
        step();
        clear_all();

        // Reset three beats into a burst: lock and pointer must clear.
        out_a_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_req(1, 1'b1, 3'd0, 3'd6, 4'd7);
            step();
        end
        do_reset();
        out_a_ready = 1'b1;
        set_req(0, 1'b1, 3'd4, 3'd3, 4'd4);
        set_req(1, 1'b1, 3'd0, 3'd6, 4'd7);
        step();

        // Random traffic on both channels.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N_IN; i++) begin
                logic [2:0] op;
                case ($urandom_range(0, 2))
                    0:       op = 3'd0;
                    1:       op = 3'd1;
                    default: op = 3'd4;
                endcase
                set_req(i, ($urandom_range(0, 9) < 7), op, 3'($urandom_range(0, 7)),
                        IN_SRC_W'($urandom));
            end
            out_a_ready = ($urandom_range(0, 3) != 0);
            drive_d(($urandom_range(0, 1) == 1), OUT_SRC_W'($urandom), N_IN'($urandom));
            step();
        end

        // Drain and make sure every prediction was matched.
        clear_all();
        for (int c = 0; c < 4; c++) step();
        check("a_queue_left", 64'(a_q.size()), 64'd0);
        check("d_queue_left", 64'(d_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_a_arbiter.md
Name: tl_a_arbiter

Overview:
- Shares one TileLink-UL master port (the fragmenter's input side of the interconnect coupler) between N_IN requesters.
- A channel: round-robin arbitration, locked for the full duration of multi-beat Put bursts. Requester index is prepended to source.
- D channel: responses are routed back to the owning requester by the source MSBs.
- Sits directly upstream of the coupler's tl_in node; output widths match it (5-bit source, 26-bit address, 64-bit data).

Parameters:
- N_IN, 2, number of requesters; power of 2, 2..4.
- IN_SRC_W, 4, requester source width; IN_SRC_W + log2(N_IN) must equal OUT_SRC_W.
- OUT_SRC_W, 5, downstream source width.
- ADDR_W, 26, address width.
- DATA_W, 64, data width; beat = 8 bytes.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- in_a_valid  in  N_IN  per-requester A valid
- in_a_ready  out  N_IN  per-requester A ready
- in_a_bits_opcode  in  3*N_IN  A opcode, requester i at slice i
- in_a_bits_size  in  3*N_IN  log2 bytes
- in_a_bits_source  in  IN_SRC_W*N_IN  requester source
- in_a_bits_address  in  ADDR_W*N_IN  byte address
- in_a_bits_mask  in  8*N_IN  byte mask
- in_a_bits_data  in  DATA_W*N_IN  write data
- in_d_valid  out  N_IN  per-requester D valid
- in_d_ready  in  N_IN  per-requester D ready
- in_d_bits_opcode  out  3  D opcode, broadcast to all requesters
- in_d_bits_size  out  3  D size, broadcast
- in_d_bits_source  out  IN_SRC_W  low source bits, broadcast
- in_d_bits_data  out  DATA_W  read data, broadcast
- out_a_valid / out_a_ready  out / in  1 / 1  downstream A handshake
- out_a_bits_opcode, size, source, address, mask, data  out  3, 3, OUT_SRC_W, ADDR_W, 8, DATA_W  downstream A payload
- out_d_valid / out_d_ready  in / out  1 / 1  downstream D handshake
- out_d_bits_opcode, size, source, data  in  3, 3, OUT_SRC_W, DATA_W  downstream D payload

Clock is "clock"; reset is "reset", synchronous and active-high.

Behaviour:
State and reset:
- Registers: rr_ptr (log2 N_IN bits), locked (1), owner (log2 N_IN bits), beats_left (3 bits).
- Reset values: rr_ptr=0, locked=0, owner=0, beats_left=0.
- Outputs are combinational from inputs and these registers, so under reset with no in_a_valid: out_a_valid=0 and in_d_valid=0.

Grant:
- Unlocked: grant = first valid requester scanning rr_ptr, rr_ptr+1, ... modulo N_IN. Zero-cycle latency.
- Locked: grant = owner, whether or not the owner is valid.

A channel:
- out_a_valid = in_a_valid[grant].
- Payload is muxed from the granted requester.
- out_a_bits_source = {grant, in source}.
- in_a_ready[i] = out_a_ready && (i==grant). Non-granted requesters see ready=0.
- fire = out_a_valid && out_a_ready.

Beat count:
- Message has data iff opcode[2]==0 (PutFull=0, PutPartial=1). Get=4 has none.
- beats = (has_data && size>3) ? 1<<(size-3) : 1.
- size>6 is clamped to 8 beats.

Lock:
- First beat fires while unlocked with beats>1: locked<=1, owner<=grant, beats_left<=beats-1.
- Fire while locked: beats_left--. When beats_left==1, locked<=0 on that fire.
- rr_ptr <= grant+1 on the fire of every single-beat message and every first beat of a burst.
- No preemption mid-burst.
- Reset asserted mid-burst clears the lock immediately; no beat is replayed.

D channel:
- sel = out_d_bits_source[OUT_SRC_W-1 -: log2 N_IN].
- in_d_valid[i] = out_d_valid && (sel==i).
- out_d_ready = in_d_ready[sel].
- Low source bits, opcode, size and data are broadcast.
- The D channel is fully combinational, independent of A, and needs no lock.

Simultaneous events:
- A fire and D fire in the same cycle are independent.
- All requesters valid: strict rotation 0,1,...,N_IN-1.
- A requester valid alone is granted immediately, regardless of rr_ptr.

Decomposition:
- Package tl_arb_pkg:
  - opcode constants PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACCESS_ACK=0, ACCESS_ACK_DATA=1
  - function has_data(opcode)
  - function num_beats(opcode, size)
  - localparam beat bytes = 8
- Sub-module rr_arbiter: N-way round-robin grant from a valid vector and a pointer, returns a one-hot grant and an index.

Test Plan:
- Single Get, req0, source 3 -> out_a_bits_source=5'b00011, fires the same cycle with out_a_ready=1; D with source 5'b00011 -> in_d_valid=2'b01, in_d_bits_source=3.
- req0 and req1 both issue single-beat Puts continuously -> grants alternate 0,1,0,1; first grant is 0 after reset.
- req1 PutFull size=6 (8 beats) with req0 valid throughout -> 8 consecutive req1 beats; req0 granted on the 9th fire; locked deasserts after beat 8.
- Burst with out_a_ready toggling 1,0,1,0 -> beats_left decrements only on fires; req0 never granted mid-burst.
- D source 5'b10111 with in_d_ready=2'b01 -> in_d_valid=2'b10, out_d_ready=0; set in_d_ready[1]=1 -> out_d_ready=1.
- Reset pulsed after 3 beats of an 8-beat burst -> locked=0, rr_ptr=0; next cycle req0 valid is granted.
